// File: rtl/qmlp_pkg.sv
// qmlp_pkg: shared definitions for the qmlp_stream encoder.
//   - default geometry and weight-chain section offsets
//   - acc_bits(): accumulator width for a signed dot product plus bias
//   - relu_quant(): rescale an accumulator and clamp it to the activation range
//   - state_e: sequencing FSM states
package qmlp_pkg;

    localparam int unsigned DEF_XD = 16;
    localparam int unsigned DEF_HD = 16;
    localparam int unsigned DEF_YD = 16;
    localparam int unsigned DEF_KB = 8;

    // Chain layout, MSB to LSB: {b2, k2, b1, k1}
    localparam int unsigned DEF_WEIGHTS_B =
        DEF_KB * (DEF_XD * DEF_HD + DEF_HD + DEF_HD * DEF_YD + DEF_YD);
    localparam int unsigned DEF_K1_OFF = 0;
    localparam int unsigned DEF_B1_OFF = DEF_K1_OFF + DEF_KB * DEF_XD * DEF_HD;
    localparam int unsigned DEF_K2_OFF = DEF_B1_OFF + DEF_KB * DEF_HD;
    localparam int unsigned DEF_B2_OFF = DEF_K2_OFF + DEF_KB * DEF_HD * DEF_YD;

    typedef enum logic [1:0] {StIdle, StL1, StL2, StDone} state_e;

    function automatic int unsigned weights_bits(input int unsigned xd, input int unsigned hd,
                                                 input int unsigned yd, input int unsigned kb);
        return kb * (xd * hd + hd + hd * yd + yd);
    endfunction

    function automatic int unsigned acc_bits(input int unsigned inbits, input int unsigned kb,
                                             input int unsigned fanin);
        return inbits + kb + $clog2(fanin + 1);
    endfunction

    // A negative shift means the accumulator has fewer fraction bits than the
    // activation format, so the value is scaled up instead of down.
    function automatic logic signed [63:0] relu_quant(input logic signed [63:0] acc,
                                                      input int shift,
                                                      input int unsigned ybq);
        logic signed [63:0] t;
        logic signed [63:0] tmax;
        if (shift >= 0) t = acc >>> shift;
        else            t = acc <<< (-shift);
        tmax = (64'sd1 <<< ybq) - 64'sd1;
        if (t < 0)    return '0;
        if (t > tmax) return tmax;
        return t;
    endfunction

endpackage

// File: rtl/qmlp_stream_lane.sv
// qmac_lane: one quantized neuron, purely combinational.
//   w_i : FANIN signed KB-bit weights, element i at [i*KB +: KB]
//   b_i : signed KB-bit bias
//   x_i : FANIN signed INB-bit inputs, element i at [i*INB +: INB]
//   y_o : YBQ-bit non-negative activation (ReLU, rescale, saturate)
module qmac_lane
    import qmlp_pkg::*;
#(
    parameter int unsigned FANIN = 16,
    parameter int unsigned INB   = 10,
    parameter int unsigned KB    = 8,
    parameter int unsigned XBF   = 12,
    parameter int unsigned YBQ   = 16,
    parameter int unsigned YBI   = 3
) (
    input  logic [FANIN*KB-1:0]  w_i,
    input  logic [KB-1:0]        b_i,
    input  logic [FANIN*INB-1:0] x_i,
    output logic [YBQ-1:0]       y_o
);

    localparam int unsigned A     = acc_bits(INB, KB, FANIN);
    localparam int          SHIFT = int'(XBF) - (int'(YBQ) - int'(YBI));

    logic signed [A-1:0] acc;

    always_comb begin
        acc = A'($signed(b_i));
        for (int i = 0; i < int'(FANIN); i++) begin
            acc = acc + A'($signed(x_i[i*INB +: INB])) * A'($signed(w_i[i*KB +: KB]));
        end
    end

    assign y_o = YBQ'(relu_quant(64'(acc), SHIFT, YBQ));

endmodule

// File: rtl/qmlp_stream.sv
// qmlp_stream: two-layer quantized MLP encoder with valid/ready streaming.
// Neurons are evaluated LANES at a time; weights arrive over a serial chain.
//   clk, rst          : clock, synchronous active-high reset
//   load_en, k        : shift weight bit k into the chain (honoured only in IDLE)
//   weights_ready     : full chain loaded since reset
//   x_valid/x_ready/x : input sample handshake, XD signed XB-bit elements
//   y_valid/y_ready/y : result handshake, YD elements of YBQ+1 bits (MSB 0)
//   tmr_err           : sticky disagreement between weight copies
// Build option: define QMLP_TMR_EN to triplicate the weight chain with a
// bitwise majority vote; otherwise a single chain is kept and tmr_err is 0.
module qmlp_stream
    import qmlp_pkg::*;
#(
    parameter int unsigned XD    = DEF_XD,
    parameter int unsigned HD    = DEF_HD,
    parameter int unsigned YD    = DEF_YD,
    parameter int unsigned XB    = 10,
    parameter int unsigned KB    = DEF_KB,
    parameter int unsigned LANES = 4,
    parameter int unsigned XBF1  = 12,
    parameter int unsigned XBF2  = 19,
    parameter int unsigned YBQ   = 16,
    parameter int unsigned YBI   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic                  k,
    output logic                  weights_ready,
    input  logic                  x_valid,
    output logic                  x_ready,
    input  logic [XD*XB-1:0]      x,
    output logic                  y_valid,
    input  logic                  y_ready,
    output logic [YD*(YBQ+1)-1:0] y,
    output logic                  tmr_err
);

    localparam int unsigned WB     = weights_bits(XD, HD, YD, KB);
    localparam int unsigned K1_OFF = 0;
    localparam int unsigned B1_OFF = K1_OFF + KB * XD * HD;
    localparam int unsigned K2_OFF = B1_OFF + KB * HD;
    localparam int unsigned B2_OFF = K2_OFF + KB * HD * YD;
    localparam int unsigned HW     = YBQ + 1;  // activation with a zero sign bit
    localparam int unsigned G1     = HD / LANES;
    localparam int unsigned G2     = YD / LANES;
    localparam int unsigned GW     = $clog2((G1 > G2 ? G1 : G2) + 1);
    localparam int unsigned CW     = $clog2(WB + 1);
    localparam int unsigned IW     = $clog2(WB);
    localparam int unsigned HIW    = $clog2(HD * HW);
    localparam int unsigned YIW    = $clog2(YD * HW);

    state_e              state_q, state_d;
    logic [GW-1:0]       g_q, g_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic                yv_q, yv_d;
    logic [XD*XB-1:0]    x_q, x_d;
    logic [HD*HW-1:0]    h_q, h_d;
    logic [YD*HW-1:0]    y_q, y_d;
    logic [WB-1:0]       w;
    logic                shift_en;

    assign shift_en = load_en && (state_q == StIdle);

`ifdef QMLP_TMR_EN
    logic [WB-1:0] wa_q, wa_d, wb_q, wb_d, wc_q, wc_d;
    logic          err_q, err_d;

    always_comb begin
        wa_d  = shift_en ? {k, wa_q[WB-1:1]} : wa_q;
        wb_d  = shift_en ? {k, wb_q[WB-1:1]} : wb_q;
        wc_d  = shift_en ? {k, wc_q[WB-1:1]} : wc_q;
        err_d = err_q || (wa_q != wb_q) || (wa_q != wc_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wa_q  <= '0;
            wb_q  <= '0;
            wc_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wa_q  <= wa_d;
            wb_q  <= wb_d;
            wc_q  <= wc_d;
            err_q <= err_d;
        end
    end

    assign w       = (wa_q & wb_q) | (wa_q & wc_q) | (wb_q & wc_q);
    assign tmr_err = err_q;
`else
    logic [WB-1:0] wq_q, wq_d;

    always_comb wq_d = shift_en ? {k, wq_q[WB-1:1]} : wq_q;

    always_ff @(posedge clk) begin
        if (rst) wq_q <= '0;
        else     wq_q <= wq_d;
    end

    assign w       = wq_q;
    assign tmr_err = 1'b0;
`endif

    // Weight rows for the neurons of the current group
    logic [XD*KB-1:0] l1_w [LANES];
    logic [KB-1:0]    l1_b [LANES];
    logic [YBQ-1:0]   l1_y [LANES];
    logic [HD*KB-1:0] l2_w [LANES];
    logic [KB-1:0]    l2_b [LANES];
    logic [YBQ-1:0]   l2_y [LANES];

    always_comb begin
        for (int l = 0; l < int'(LANES); l++) begin
            l1_w[l] = w[IW'(K1_OFF + (g_q * LANES + l) * XD * KB) +: XD*KB];
            l1_b[l] = w[IW'(B1_OFF + (g_q * LANES + l) * KB) +: KB];
            l2_w[l] = w[IW'(K2_OFF + (g_q * LANES + l) * HD * KB) +: HD*KB];
            l2_b[l] = w[IW'(B2_OFF + (g_q * LANES + l) * KB) +: KB];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        qmac_lane #(
            .FANIN(XD), .INB(XB), .KB(KB), .XBF(XBF1), .YBQ(YBQ), .YBI(YBI)
        ) u_l1 (
            .w_i(l1_w[l]), .b_i(l1_b[l]), .x_i(x_q), .y_o(l1_y[l])
        );
        qmac_lane #(
            .FANIN(HD), .INB(HW), .KB(KB), .XBF(XBF2), .YBQ(YBQ), .YBI(YBI)
        ) u_l2 (
            .w_i(l2_w[l]), .b_i(l2_b[l]), .x_i(h_q), .y_o(l2_y[l])
        );
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        x_d     = x_q;
        h_d     = h_q;
        y_d     = y_q;
        yv_d    = 1'b0;
        cnt_d   = (shift_en && cnt_q != CW'(WB)) ? cnt_q + CW'(1) : cnt_q;
        wr_d    = (cnt_d == CW'(WB));
        unique case (state_q)
            StIdle: begin
                if (x_valid && x_ready) begin
                    x_d     = x;
                    g_d     = '0;
                    state_d = StL1;
                end
            end
            StL1: begin
                for (int l = 0; l < int'(LANES); l++) begin
                    h_d[HIW'((g_q * LANES + l) * HW) +: HW] = {1'b0, l1_y[l]};
                end
                if (g_q == GW'(G1 - 1)) begin
                    g_d     = '0;
                    state_d = StL2;
                end else begin
                    g_d = g_q + GW'(1);
                end
            end
            StL2: begin
                for (int l = 0; l < int'(LANES); l++) begin
                    y_d[YIW'((g_q * LANES + l) * HW) +: HW] = {1'b0, l2_y[l]};
                end
                if (g_q == GW'(G2 - 1)) begin
                    g_d     = '0;
                    state_d = StDone;
                end else begin
                    g_d = g_q + GW'(1);
                end
            end
            StDone: begin
                // y_valid is registered: it rises one edge after the last
                // output group lands and drops on the handshake edge.
                yv_d = !(yv_q && y_ready);
                if (yv_q && y_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            g_q     <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            yv_q    <= 1'b0;
            x_q     <= '0;
            h_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            yv_q    <= yv_d;
            x_q     <= x_d;
            h_q     <= h_d;
            y_q     <= y_d;
        end
    end

    assign weights_ready = wr_q;
    assign x_ready       = (state_q == StIdle) && wr_q;
    assign y_valid       = yv_q;
    assign y             = y_q;

endmodule

// File: tb/tb_qmlp_stream.sv
// Bench for qmlp_stream: scoreboard of golden results pushed at the accept
// edge and popped when the result is presented.
module tb_qmlp_stream;

    localparam int XD = 16, HD = 16, YD = 16, XB = 10, KB = 8;
    localparam int YW = 17;
    localparam int WB = KB * (XD * HD + HD + HD * YD + YD);
    localparam int B1_OFF = KB * XD * HD;
    localparam int K2_OFF = B1_OFF + KB * HD;
    localparam int B2_OFF = K2_OFF + KB * HD * YD;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               load_en = 1'b0;
    logic               k = 1'b0;
    logic               weights_ready;
    logic               x_valid = 1'b0;
    logic               x_ready;
    logic [XD*XB-1:0]   x = '0;
    logic               y_valid;
    logic               y_ready = 1'b0;
    logic [YD*YW-1:0]   y;
    logic               tmr_err;

    qmlp_stream dut (
        .clk(clk), .rst(rst), .load_en(load_en), .k(k), .weights_ready(weights_ready),
        .x_valid(x_valid), .x_ready(x_ready), .x(x),
        .y_valid(y_valid), .y_ready(y_ready), .y(y), .tmr_err(tmr_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int k1[HD*XD], b1[HD], k2[YD*HD], b2[YD], xs[XD];
    logic [YD*YW-1:0] sb[$];

    task automatic check_eq(input string tag, input logic [YD*YW-1:0] got,
                            input logic [YD*YW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint act(input longint acc, input int xbf);
        longint t;
        int s = xbf - 13;
        t = (s < 0) ? (acc <<< (-s)) : (acc >>> s);
        if (t < 0) t = 0;
        if (t > 65535) t = 65535;
        return t;
    endfunction

    function automatic logic [YD*YW-1:0] golden();
        logic [YD*YW-1:0] r;
        longint h[HD];
        longint acc;
        r = '0;
        for (int j = 0; j < HD; j++) begin
            acc = b1[j];
            for (int i = 0; i < XD; i++) acc += longint'(k1[j*XD+i]) * xs[i];
            h[j] = act(acc, 12);
        end
        for (int o = 0; o < YD; o++) begin
            acc = b2[o];
            for (int j = 0; j < HD; j++) acc += longint'(k2[o*HD+j]) * h[j];
            r[o*YW +: YW] = YW'(act(acc, 19));
        end
        return r;
    endfunction

    task automatic set_weights(input int kv, input int bv);
        foreach (k1[i]) k1[i] = kv;
        foreach (k2[i]) k2[i] = kv;
        foreach (b1[i]) b1[i] = bv;
        foreach (b2[i]) b2[i] = bv;
    endtask

    task automatic load_weights(input bit fresh);
        logic [WB-1:0] wv;
        for (int j = 0; j < HD; j++) begin
            for (int i = 0; i < XD; i++) wv[(j*XD+i)*KB +: KB] = KB'(k1[j*XD+i]);
            wv[B1_OFF + j*KB +: KB] = KB'(b1[j]);
        end
        for (int o = 0; o < YD; o++) begin
            for (int j = 0; j < HD; j++) wv[K2_OFF + (o*HD+j)*KB +: KB] = KB'(k2[o*HD+j]);
            wv[B2_OFF + o*KB +: KB] = KB'(b2[o]);
        end
        for (int n = 0; n < WB; n++) begin
            @(negedge clk);
            if (fresh && n == WB - 1) check_eq("ready_before_last", weights_ready, 0);
            load_en = 1'b1;
            k = wv[n];
        end
        @(negedge clk);
        load_en = 1'b0;
        check_eq("weights_ready", weights_ready, 1);
        check_eq("x_ready_loaded", x_ready, 1);
    endtask

    task automatic run_sample(input int stall);
        logic [YD*YW-1:0] exp;
        int n;
        for (int i = 0; i < XD; i++) x[i*XB +: XB] = XB'(xs[i]);
        n = 0;
        while (!x_ready && n < 20) begin @(negedge clk); n++; end
        check_eq("x_ready_wait", x_ready, 1);
        x_valid = 1'b1;
        @(posedge clk);
        sb.push_back(golden());
        @(negedge clk);
        x_valid = 1'b0;
        n = 0;
        while (!y_valid && n < 50) begin @(posedge clk); n++; @(negedge clk); end
        check_eq("latency", n, 9);
        // Offer another sample while stalled; it must not be taken.
        x_valid = 1'b1;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check_eq("stall_x_ready", x_ready, 0);
            check_eq("stall_y_valid", y_valid, 1);
            check_eq("stall_y", y, sb[0]);
        end
        x_valid = 1'b0;
        exp = sb.pop_front();
        check_eq("y", y, exp);
        y_ready = 1'b1;
        @(negedge clk);
        y_ready = 1'b0;
        check_eq("y_valid_drop", y_valid, 0);
        check_eq("x_ready_idle", x_ready, 1);
    endtask

`ifdef QMLP_TMR_EN
    logic [WB-1:0] flipped;
`endif

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_weights_ready", weights_ready, 0);
        check_eq("rst_x_ready", x_ready, 0);
        check_eq("rst_y_valid", y_valid, 0);
        check_eq("rst_y", y, 0);
        check_eq("rst_tmr_err", tmr_err, 0);
        rst = 1'b0;

        // All ones, zero bias: hidden 32, outputs 8
        set_weights(1, 0);
        load_weights(1'b1);
        foreach (xs[i]) xs[i] = 1;
        run_sample(20);

        // Negative row 0 clamps hidden 0 to zero
        k1[0:XD-1] = '{default: -1};
        foreach (xs[i]) xs[i] = 5;
        load_weights(1'b0);
        run_sample(0);

        // Saturation at both layers
        set_weights(127, 127);
        load_weights(1'b0);
        foreach (xs[i]) xs[i] = 511;
        run_sample(2);
        foreach (xs[i]) xs[i] = -512;
        run_sample(0);

        // Random weights and inputs
        foreach (k1[i]) k1[i] = int'($urandom_range(0, 255)) - 128;
        foreach (k2[i]) k2[i] = int'($urandom_range(0, 255)) - 128;
        foreach (b1[i]) b1[i] = int'($urandom_range(0, 255)) - 128;
        foreach (b2[i]) b2[i] = int'($urandom_range(0, 255)) - 128;
        load_weights(1'b0);
        for (int r = 0; r < 3; r++) begin
            foreach (xs[i]) xs[i] = int'($urandom_range(0, 1023)) - 512;
            run_sample(r);
        end

        // Reset in the middle of layer 2
        x_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        x_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_y_valid", y_valid, 0);
        check_eq("abort_weights_ready", weights_ready, 0);
        check_eq("abort_x_ready", x_ready, 0);
        check_eq("abort_y", y, 0);

        load_weights(1'b1);
        foreach (xs[i]) xs[i] = int'($urandom_range(0, 1023)) - 512;
        run_sample(1);

`ifdef QMLP_TMR_EN
        flipped = dut.wb_q ^ WB'(1);
        force dut.wb_q = flipped;
        @(negedge clk);
        @(negedge clk);
        check_eq("tmr_err_set", tmr_err, 1);
        run_sample(0);
        release dut.wb_q;
        @(negedge clk);
        check_eq("tmr_err_sticky", tmr_err, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("tmr_err_cleared", tmr_err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
